// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB completion arbiter: FU indices, completion packet
// and the three-slot CDB tag packet consumed by RS, map table and ROB.
package cdb_arbiter_pkg;

    localparam int NFU   = 8;
    localparam int PRW   = 6;
    localparam int XLEN  = 32;
    localparam int NSLOT = 3;

    // Index order matches FU_SELECT.
    typedef enum logic [2:0] {
        FU_ALU_1  = 3'd0,
        FU_ALU_2  = 3'd1,
        FU_ALU_3  = 3'd2,
        FU_LS_1   = 3'd3,
        FU_LS_2   = 3'd4,
        FU_MULT_1 = 3'd5,
        FU_MULT_2 = 3'd6,
        FU_BRANCH = 3'd7
    } fu_select_e;

    typedef struct packed {
        logic            valid;
        logic [PRW-1:0]  dest_pr;
        logic [XLEN-1:0] value;
    } FU_COMPLETE_PACKET;

    typedef struct packed {
        logic [PRW-1:0] t2;
        logic [PRW-1:0] t1;
        logic [PRW-1:0] t0;
    } CDB_T_PACKET;

    function automatic logic [2:0] ptr_inc(input logic [2:0] p);
        return p + 3'd1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Completion bus between the functional units (master) and the CDB arbiter (slave).
// Handshake: fu_done[i].valid offers a result; it is taken at the edge when fu_stall[i] is low, otherwise it must be held unchanged.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    FU_COMPLETE_PACKET [NFU-1:0]          fu_done;
    logic              [NFU-1:0]          fu_stall;
    CDB_T_PACKET                          cdb_t;
    logic              [NSLOT-1:0]        cdb_valid;
    logic              [NSLOT-1:0][XLEN-1:0] cdb_value;

    modport master (
        output fu_done,
        input  fu_stall, cdb_t, cdb_valid, cdb_value
    );

    modport slave (
        input  fu_done,
        output fu_stall, cdb_t, cdb_valid, cdb_value
    );

endinterface

// File: rtl/cdb_arbiter_rr_sel3.sv
// Rotating 3-of-8 selector: scans requests from i_ptr upward (mod 8) and hands
// the first three hits to slots 0, 1, 2 as one-hot grants.
module rr_sel3
    import cdb_arbiter_pkg::*;
(
    input  logic [NFU-1:0]   i_req,
    input  logic [2:0]       i_ptr,
    output logic [NFU-1:0]   o_gnt0,
    output logic [NFU-1:0]   o_gnt1,
    output logic [NFU-1:0]   o_gnt2,
    output logic [NSLOT-1:0] o_slot_vld,
    output logic [2:0]       o_next_ptr
);

    logic [1:0] w_cnt;
    logic [2:0] w_idx;
    logic [2:0] w_last;

    always_comb begin
        o_gnt0 = '0;
        o_gnt1 = '0;
        o_gnt2 = '0;
        w_cnt  = 2'd0;
        w_idx  = i_ptr;
        w_last = i_ptr;
        for (int k = 0; k < NFU; k++) begin
            w_idx = i_ptr + 3'(k);
            if (i_req[w_idx] && (w_cnt != 2'd3)) begin
                case (w_cnt)
                    2'd0:    o_gnt0[w_idx] = 1'b1;
                    2'd1:    o_gnt1[w_idx] = 1'b1;
                    default: o_gnt2[w_idx] = 1'b1;
                endcase
                w_last = w_idx;
                w_cnt  = w_cnt + 2'd1;
            end
        end
    end

    assign o_slot_vld = {(w_cnt == 2'd3), (w_cnt >= 2'd2), (w_cnt != 2'd0)};
    // Restart one past the last winner so skipped-over requesters lead next time.
    assign o_next_ptr = (w_cnt == 2'd0) ? i_ptr : ptr_inc(w_last);

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one result buffer per FU, up to three registered broadcasts per
// cycle chosen by rotating priority, with stall back-pressure on undrained buffers.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    cdb_arbiter_if.slave bus,
    output logic [2:0]   o_dbg_rr_ptr
);

    FU_COMPLETE_PACKET [NFU-1:0]             r_buf;
    logic              [2:0]                 r_rr_ptr;
    CDB_T_PACKET                             r_cdb_t;
    logic              [NSLOT-1:0]           r_cdb_valid;
    logic              [NSLOT-1:0][XLEN-1:0] r_cdb_value;

    logic [NFU-1:0]                  w_req;
    logic [NSLOT-1:0][NFU-1:0]       w_gnt;
    logic [NFU-1:0]                  w_grant;
    logic [NFU-1:0]                  w_stall;
    logic [NSLOT-1:0]                w_slot_vld;
    logic [2:0]                      w_next_ptr;
    logic [NSLOT-1:0][PRW-1:0]       w_tag;
    logic [NSLOT-1:0][XLEN-1:0]      w_val;

    always_comb begin
        for (int i = 0; i < NFU; i++) begin
            w_req[i] = r_buf[i].valid;
        end
    end

    rr_sel3 u_sel (
        .i_req      (w_req),
        .i_ptr      (r_rr_ptr),
        .o_gnt0     (w_gnt[0]),
        .o_gnt1     (w_gnt[1]),
        .o_gnt2     (w_gnt[2]),
        .o_slot_vld (w_slot_vld),
        .o_next_ptr (w_next_ptr)
    );

    assign w_grant = w_gnt[0] | w_gnt[1] | w_gnt[2];
    // Depends only on buffer state, so an FU can never create a loop through fu_done.
    assign w_stall = w_req & ~w_grant;

    always_comb begin
        w_tag = '0;
        w_val = '0;
        for (int s = 0; s < NSLOT; s++) begin
            for (int i = 0; i < NFU; i++) begin
                if (w_gnt[s][i]) begin
                    w_tag[s] = r_buf[i].dest_pr;
                    w_val[s] = r_buf[i].value;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_buf       <= '0;
            r_rr_ptr    <= '0;
            r_cdb_t     <= '0;
            r_cdb_valid <= '0;
            r_cdb_value <= '0;
        end else begin
            // Tag-0 results (stores, plain branches) are acknowledged and dropped.
            for (int i = 0; i < NFU; i++) begin
                if (bus.fu_done[i].valid && !w_stall[i] && (bus.fu_done[i].dest_pr != '0)) begin
                    r_buf[i] <= bus.fu_done[i];
                end else if (w_grant[i]) begin
                    r_buf[i].valid <= 1'b0;
                end
            end
            r_rr_ptr    <= w_next_ptr;
            r_cdb_t.t0  <= w_tag[0];
            r_cdb_t.t1  <= w_tag[1];
            r_cdb_t.t2  <= w_tag[2];
            r_cdb_valid <= w_slot_vld;
            r_cdb_value <= w_val;
        end
    end

    assign bus.fu_stall  = w_stall;
    assign bus.cdb_t     = r_cdb_t;
    assign bus.cdb_valid = r_cdb_valid;
    assign bus.cdb_value = r_cdb_value;
    assign o_dbg_rr_ptr  = r_rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and random stimulus for cdb_arbiter with a per-cycle expected queue
// built from an independent slot-scan model of the buffers and rotation pointer.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic [2:0] dbg_ptr;

  always #5 clock = ~clock;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .o_dbg_rr_ptr (dbg_ptr)
  );

  typedef struct packed {
    logic [NFU-1:0]             stall;
    logic [2:0]                 ptr;
    logic [2:0]                 vld;
    logic [2:0][PRW-1:0]        tag;
    logic [2:0][XLEN-1:0]       val;
  } exp_t;

  localparam int W = $bits(exp_t);
  logic [W-1:0] exp_q[$];

  logic [NFU-1:0]            m_bv;
  logic [NFU-1:0][PRW-1:0]   m_bd;
  logic [NFU-1:0][XLEN-1:0]  m_bx;
  logic [NFU-1:0]            m_acc;
  int                        m_ptr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic void scan(input logic [NFU-1:0] v, input int p,
                               output logic [2:0][2:0] sl, output int n);
    n  = 0;
    sl = '0;
    for (int k = 0; k < NFU; k++) begin
      int idx;
      idx = (p + k) % NFU;
      if (v[idx] && n < 3) begin
        sl[n] = 3'(idx);
        n++;
      end
    end
  endfunction

  // Advance the model across the coming edge and queue what the DUT must show after it.
  task automatic model_step();
    logic [2:0][2:0] sl;
    int              n;
    logic [NFU-1:0]  gr;
    logic [NFU-1:0]  st;
    exp_t            e;
    e  = '0;
    gr = '0;
    scan(m_bv, m_ptr, sl, n);
    for (int s = 0; s < n; s++) gr[sl[s]] = 1'b1;
    if (reset) begin
      m_bv  = '0;
      m_bd  = '0;
      m_bx  = '0;
      m_ptr = 0;
      m_acc = '1;
    end else begin
      for (int s = 0; s < n; s++) begin
        e.vld[s] = 1'b1;
        e.tag[s] = m_bd[sl[s]];
        e.val[s] = m_bx[sl[s]];
      end
      st = m_bv & ~gr;
      for (int i = 0; i < NFU; i++) begin
        m_acc[i] = !st[i];
        if (gr[i]) m_bv[i] = 1'b0;
        if (bus.fu_done[i].valid && !st[i] && bus.fu_done[i].dest_pr != '0) begin
          m_bv[i] = 1'b1;
          m_bd[i] = bus.fu_done[i].dest_pr;
          m_bx[i] = bus.fu_done[i].value;
        end
      end
      if (n > 0) m_ptr = (int'(sl[n-1]) + 1) % NFU;
    end
    e.ptr = 3'(m_ptr);
    scan(m_bv, m_ptr, sl, n);
    gr = '0;
    for (int s = 0; s < n; s++) gr[sl[s]] = 1'b1;
    e.stall = m_bv & ~gr;
    exp_q.push_back(W'(e));
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 1'b1, 1'b0);
    end else begin
      e = exp_t'(exp_q.pop_front());
      chk("fu_stall", bus.fu_stall, e.stall);
      chk("rr_ptr", dbg_ptr, e.ptr);
      chk("cdb_valid", bus.cdb_valid, e.vld);
      chk("cdb_t", {bus.cdb_t.t2, bus.cdb_t.t1, bus.cdb_t.t0}, e.tag);
      chk("cdb_value", bus.cdb_value, e.val);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [PRW-1:0] d, input logic [XLEN-1:0] x);
    bus.fu_done[i] = {v, d, x};
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, bus.cdb_valid, 3'b000);
    chk({tag, "_tags"}, {bus.cdb_t.t2, bus.cdb_t.t1, bus.cdb_t.t0}, 18'd0);
    chk({tag, "_stall"}, bus.fu_stall, 8'h00);
  endtask

  int fseq[4];
  int last_seen[4];

  initial begin
    m_bv  = '0;
    m_bd  = '0;
    m_bx  = '0;
    m_acc = '1;
    m_ptr = 0;
    bus.fu_done = '0;

    // Reset held two cycles with every FU offering a result.
    reset = 1'b1;
    for (int i = 0; i < NFU; i++) drive(i, 1'b1, 6'(i + 1), 32'(i));
    cycle();
    chk_idle("reset1");
    chk("reset1_value", bus.cdb_value, 96'd0);
    cycle();
    chk_idle("reset2");
    reset = 1'b0;
    bus.fu_done = '0;
    cycle();
    chk_idle("post_reset1");
    cycle();
    chk_idle("post_reset2");

    // Single result from ALU_1.
    drive(FU_ALU_1, 1'b1, 6'd5, 32'hDEAD);
    cycle();
    drive(FU_ALU_1, 1'b0, 6'd0, 32'd0);
    cycle();
    chk("single_t0", bus.cdb_t.t0, 6'd5);
    chk("single_valid", bus.cdb_valid, 3'b001);
    chk("single_value", bus.cdb_value[0], 32'hDEAD);
    chk("single_t1t2", {bus.cdb_t.t2, bus.cdb_t.t1}, 12'd0);

    // Contention from rr_ptr = 0: all eight FUs at once.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < NFU; i++) drive(i, 1'b1, 6'(10 + i), 32'h100 + 32'(i));
    cycle();
    bus.fu_done = '0;
    chk("cont_stall0", bus.fu_stall, 8'hF8);
    cycle();
    chk("cont_b1_tags", {bus.cdb_t.t2, bus.cdb_t.t1, bus.cdb_t.t0}, {6'd12, 6'd11, 6'd10});
    chk("cont_b1_valid", bus.cdb_valid, 3'b111);
    chk("cont_stall1", bus.fu_stall, 8'hC0);
    cycle();
    chk("cont_b2_tags", {bus.cdb_t.t2, bus.cdb_t.t1, bus.cdb_t.t0}, {6'd15, 6'd14, 6'd13});
    chk("cont_stall2", bus.fu_stall, 8'h00);
    cycle();
    chk("cont_b3_tags", {bus.cdb_t.t2, bus.cdb_t.t1, bus.cdb_t.t0}, {6'd0, 6'd17, 6'd16});
    chk("cont_b3_valid", bus.cdb_valid, 3'b011);
    chk("cont_b3_value1", bus.cdb_value[1], 32'h107);
    chk("cont_ptr_end", dbg_ptr, 3'd0);

    // Drain-and-refill on MULT_1.
    drive(FU_MULT_1, 1'b1, 6'd19, 32'h19);
    cycle();
    chk("refill_no_stall", bus.fu_stall[FU_MULT_1], 1'b0);
    drive(FU_MULT_1, 1'b1, 6'd20, 32'h20);
    cycle();
    chk("refill_first", bus.cdb_t.t0, 6'd19);
    drive(FU_MULT_1, 1'b0, 6'd0, 32'd0);
    cycle();
    chk("refill_second", bus.cdb_t.t0, 6'd20);
    chk("refill_value", bus.cdb_value[0], 32'h20);

    // Tag 0 from BRANCH is swallowed alongside a real LS_1 result.
    drive(FU_BRANCH, 1'b1, 6'd0, 32'h77);
    drive(FU_LS_1, 1'b1, 6'd7, 32'h33);
    cycle();
    chk("dest0_stall", bus.fu_stall, 8'h00);
    bus.fu_done = '0;
    cycle();
    chk("dest0_t0", bus.cdb_t.t0, 6'd7);
    chk("dest0_valid", bus.cdb_valid, 3'b001);
    chk("dest0_value", bus.cdb_value[0], 32'h33);
    cycle();
    chk("dest0_none", bus.cdb_valid, 3'b000);

    // Fairness: FUs 0-3 always offering results.
    for (int i = 0; i < 4; i++) begin
      fseq[i] = 0;
      last_seen[i] = 0;
    end
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.fu_done[i].valid || m_acc[i]) begin
          drive(i, 1'b1, 6'(40 + i), {4'(i), 28'(fseq[i])});
          fseq[i]++;
        end
      end
      cycle();
      for (int s = 0; s < 3; s++) begin
        if (bus.cdb_valid[s] && bus.cdb_value[s][31:28] < 4) last_seen[bus.cdb_value[s][31:28]] = c;
      end
      if (c >= 4) begin
        for (int i = 0; i < 4; i++) chk("fair_window", 1'((c - last_seen[i]) < 3), 1'b1);
      end
    end

    // Random traffic; stalled FUs hold their offer.
    for (int c = 0; c < 150; c++) begin
      for (int i = 0; i < NFU; i++) begin
        if (!bus.fu_done[i].valid || m_acc[i]) begin
          drive(i, 1'($urandom_range(0, 2) != 0),
                ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                32'($urandom));
        end
      end
      cycle();
    end

    // Reset in the middle of heavy traffic discards everything.
    for (int i = 0; i < NFU; i++) drive(i, 1'b1, 6'(i + 1), 32'hA0 + 32'(i));
    cycle();
    bus.fu_done = '0;
    cycle();
    reset = 1'b1;
    cycle();
    chk_idle("midreset");
    reset = 1'b0;
    cycle();
    chk_idle("midreset_after1");
    cycle();
    chk_idle("midreset_after2");

    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Completion-side producer of the CDB tag broadcast that the reservation station, map table and ROB consume. Collects finished results from the eight functional units, buffers one result per FU, and selects up to three per cycle with rotating priority to drive `cdb_t` (t0/t1/t2), plus the matching physical-register-file write data. Back-pressures an FU whose buffer is occupied and not drained, so no completion is ever lost.

## Interface
Parameters:
- `NFU`, 8. Number of functional units. Index order: ALU_1, ALU_2, ALU_3, LS_1, LS_2, MULT_1, MULT_2, BRANCH (same order as `FU_SELECT`).
- `PRW`, `` `PR ``. Physical register tag width.
- `XLEN`, 32. Result width.

Ports:
- `clock`  in  1. Sole clock.
- `reset`  in  1. Synchronous, active-high.
- `fu_done`  in  `NFU` x FU_COMPLETE_PACKET. Per FU: {`valid`, `dest_pr[PRW-1:0]`, `value[XLEN-1:0]`}.
- `fu_stall`  out  `NFU`. High means FU i must hold `fu_done[i]` stable; it is not accepted this cycle.
- `cdb_t`  out  CDB_T_PACKET. Tags t0, t1, t2; value 0 means no broadcast in that slot.
- `cdb_valid`  out  3. Slot k broadcasting.
- `cdb_value`  out  3 x `XLEN`. PRF write data for slot k.

## Operation
- State:
  - `buf[NFU]`: {valid, dest_pr, value}.
  - `rr_ptr[2:0]`.
  - Registered CDB outputs.
- Grant: scan buffer indices `rr_ptr`, `rr_ptr+1`, … (mod 8). The first three valid entries get grant slots 0, 1, 2, in scan order. Fewer than three valid entries leaves the remaining slots empty.
- On each clock edge (not reset):
  - Slot k output ← granted entry: `cdb_t.tk` = dest_pr, `cdb_valid[k]` = 1, `cdb_value[k]` = value.
  - Empty slot: tag 0, valid 0, value 0.
  - Granted buffers clear.
- `fu_stall[i] = buf[i].valid & ~grant[i]`. Combinational, from current buffer state and grant only; never from `fu_done`.
- Capture: when `fu_done[i].valid & ~fu_stall[i]`, `buf[i]` ← `fu_done[i]` at the edge. This includes the same-cycle drain-and-refill case.
- `dest_pr == 0` (store, branch without link): the result is accepted, never buffered, never broadcast, never stalls.
- `rr_ptr` update: becomes (index of last granted entry + 1) mod 8. Unchanged when there are no grants. This guarantees any occupied buffer is granted within 3 cycles.
- Physical register 0 is never allocated as a destination. Tag 0 on the CDB therefore never matches a live source.

## Timing
- Reset values:
  - All buffers invalid.
  - `rr_ptr` = 0.
  - `cdb_t` = 0, `cdb_valid` = 0, `cdb_value` = 0.
  - `fu_stall` = 0.
- Latency:
  - `fu_done[i].valid` in cycle n with `buf[i]` empty → buffered at edge n+1 → broadcast in cycle n+1 if granted (outputs valid after edge n+2).
  - Minimum 2 edges; maximum 4 edges under full contention.
- Broadcast is one cycle per result; no tag is repeated.
- Throughput: 3 results/cycle sustained.
- Reset mid-operation: all buffered results and pending broadcasts are discarded. The pipeline flush owns recovery.
- A stalled FU must keep `fu_done` constant until `fu_stall` deasserts. Changes while stalled are ignored.

## Structure
- Shared package additions:
  - FU_COMPLETE_PACKET typedef.
  - `NFU` and FU index constants aligned with `FU_SELECT`.
- Reuse the existing CDB_T_PACKET.
- One sub-module: `rr_sel3`. Combinational rotating 3-of-8 selector. Inputs: req[7:0], ptr[2:0]. Outputs: three one-hot grants plus per-slot valid, and next_ptr.

## Test plan
- Reset: hold `reset` for 2 cycles with all `fu_done` valid → all outputs 0, `fu_stall` = 0, nothing broadcast after release until a new capture.
- Single result: ALU_1 done, dest_pr=5, value=0xDEAD in cycle 1 → after edge 3, t0=5, `cdb_valid`=3'b001, `cdb_value[0]`=0xDEAD; t1=t2=0.
- Contention: all 8 FUs done simultaneously, dest_pr = 10..17, `rr_ptr`=0:
  - Broadcasts are {10,11,12}, then {13,14,15}, then {16,17}.
  - `fu_stall` follows: 5, then 2, then 0 FUs held.
  - `rr_ptr` ends at 0.
- Drain-and-refill: MULT_1 buffered and granted while presenting a new result (dest 20) → `fu_stall[5]`=0; 20 is broadcast the next cycle.
- dest_pr=0: BRANCH done with dest 0 alongside LS_1 dest 7 → only 7 is broadcast (slot 0); no stall on BRANCH.
- Fairness: FUs 0–3 continuously done → every FU broadcasts at least once in any 3-cycle window; the rotation order is checked against `rr_ptr`.
